// File: rtl/rx_os_lane_tracker.sv
//------------------------------------------------------------------------------
// rx_os_lane_tracker
//
// Purpose:
//   Multi-lane ordered-set checker and consecutive-count tracker for the RX
//   LTSSM path. Each lane checks incoming TS1/TS2 ordered sets against a rule
//   chosen by the current LTSSM substate. It counts identical consecutive
//   matching ordered sets, saturating at TARGET. The block also reports
//   aggregate done flags over the enabled lanes. When every enabled lane first
//   reaches TARGET, it captures the rate ID and the upconfigure-capability bit.
//
// Handshake:
//   os_valid[i] is a one-cycle strobe that qualifies os_data for lane i. There
//   is no back-pressure: every strobed ordered set is consumed at the clock
//   edge that samples it.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   clear        in   synchronous clear of counts, signatures and captures
//   substate     in   LTSSM substate (selects the match rule)
//   link_number  in   expected link number
//   lane_enable  in   lanes that take part in all_done / any_done
//   os_valid     in   per-lane ordered-set strobe
//   os_data      in   per-lane 128-bit ordered set; lane i at [128i+127:128i],
//                     symbol k at [8k+7:8k] within a lane
//   lane_count   out  per-lane consecutive count, lane i at [CNT_W*i +: CNT_W]
//   lane_match   out  last strobed ordered set on the lane matched the rule
//   all_done     out  every enabled lane has count == TARGET
//   any_done     out  at least one enabled lane has count == TARGET
//   rate_id      out  captured rate identifier (symbol 4)
//   upconfig     out  captured upconfigure-capability bit (symbol 5 bit 6)
//------------------------------------------------------------------------------
module rx_os_lane_tracker #(
   parameter int NUM_LANES = 16,
   parameter int CNT_W     = 5,
   parameter int TARGET    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic [3:0]                   substate,
   input  logic [7:0]                   link_number,
   input  logic [NUM_LANES-1:0]         lane_enable,
   input  logic [NUM_LANES-1:0]         os_valid,
   input  logic [NUM_LANES*128-1:0]     os_data,
   output logic [NUM_LANES*CNT_W-1:0]   lane_count,
   output logic [NUM_LANES-1:0]         lane_match,
   output logic                         all_done,
   output logic                         any_done,
   output logic [7:0]                   rate_id,
   output logic                         upconfig
);

   // Ordered-set field values.
   localparam logic [7:0] PAD    = 8'hF7;
   localparam logic [7:0] ID_TS1 = 8'h2A;
   localparam logic [7:0] ID_TS2 = 8'h25;

   // LTSSM substate encodings that have a match rule.
   localparam logic [3:0] SS_POLL_ACTIVE   = 4'd2;
   localparam logic [3:0] SS_POLL_CONFIG   = 4'd3;
   localparam logic [3:0] SS_CFG_LW_START  = 4'd4;
   localparam logic [3:0] SS_CFG_LW_ACCEPT = 4'd5;
   localparam logic [3:0] SS_CFG_LN_WAIT   = 4'd6;
   localparam logic [3:0] SS_CFG_COMPLETE  = 4'd8;

   // The signature is symbols 1..5 of an ordered set:
   //   [7:0] link, [15:8] lane, [23:16] symbol 3, [31:24] rate ID,
   //   [39:32] symbol 5 (bit 38 = upconfigure capability).
   localparam int SIG_W = 40;

   localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [CNT_W-1:0]     cnt_q [NUM_LANES];
   logic [CNT_W-1:0]     cnt_d [NUM_LANES];
   logic [SIG_W-1:0]     sig_q [NUM_LANES];
   logic [SIG_W-1:0]     sig_d [NUM_LANES];
   logic [NUM_LANES-1:0] sig_vld_q;
   logic [NUM_LANES-1:0] sig_vld_d;
   logic [NUM_LANES-1:0] match_q;
   logic [NUM_LANES-1:0] match_d;
   logic [3:0]           prev_substate_q;
   logic                 all_done_q;
   logic                 all_done_d;
   logic                 any_done_q;
   logic                 any_done_d;
   logic [7:0]           rate_id_q;
   logic [7:0]           rate_id_d;
   logic                 upconfig_q;
   logic                 upconfig_d;

   logic                 substate_chg;
   logic [NUM_LANES-1:0] os_hit;
   logic [127:0]         lane_os;
   logic                 cap_found;

   //---------------------------------------------------------------------------
   // Match rule for one lane's ordered set under the given substate.
   //---------------------------------------------------------------------------
   function automatic logic os_match(
      input logic [127:0] os,
      input logic [3:0]   ss,
      input logic [7:0]   link_num,
      input logic [7:0]   lane_idx
   );
      logic       is_ts1;
      logic       is_ts2;
      logic [7:0] link;
      logic [7:0] lane;
      logic       hit;
      link   = os[15:8];
      lane   = os[23:16];
      // Identifier occupies symbols 7..10.
      is_ts1 = (os[63:56] == ID_TS1) && (os[71:64] == ID_TS1) &&
               (os[79:72] == ID_TS1) && (os[87:80] == ID_TS1);
      is_ts2 = (os[63:56] == ID_TS2) && (os[71:64] == ID_TS2) &&
               (os[79:72] == ID_TS2) && (os[87:80] == ID_TS2);
      hit    = 1'b0;
      case (ss)
         SS_POLL_ACTIVE:   hit = (is_ts1 || is_ts2) && (link == PAD) && (lane == PAD);
         SS_POLL_CONFIG:   hit = is_ts2 && (link == PAD) && (lane == PAD);
         SS_CFG_LW_START:  hit = is_ts1 && (link == link_num) && (lane == PAD);
         SS_CFG_LW_ACCEPT,
         SS_CFG_LN_WAIT:   hit = is_ts1 && (link == link_num) && (lane == lane_idx);
         SS_CFG_COMPLETE:  hit = is_ts2 && (link == link_num) && (lane == lane_idx);
         default:          hit = 1'b0;
      endcase
      return hit;
   endfunction

   //---------------------------------------------------------------------------
   // Per-lane next-state: match, signature compare, saturating count.
   //---------------------------------------------------------------------------
   always_comb begin
      substate_chg = (substate != prev_substate_q);
      os_hit       = '0;
      lane_os      = '0;
      sig_vld_d    = sig_vld_q;
      match_d      = match_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         cnt_d[i] = cnt_q[i];
         sig_d[i] = sig_q[i];
      end

      for (int i = 0; i < NUM_LANES; i++) begin
         lane_os   = os_data[128*i +: 128];
         os_hit[i] = os_match(lane_os, substate, link_number, 8'(i));

         if (clear) begin
            cnt_d[i]     = '0;
            sig_vld_d[i] = 1'b0;
            match_d[i]   = 1'b0;
         end else if (os_valid[i]) begin
            match_d[i] = os_hit[i];
            if (!os_hit[i]) begin
               cnt_d[i]     = '0;
               sig_vld_d[i] = 1'b0;
            end else if (sig_vld_q[i] && !substate_chg &&
                         (sig_q[i] == lane_os[47:8])) begin
               // Identical consecutive OS: count up, holding at TARGET.
               cnt_d[i] = (cnt_q[i] >= TARGET_C) ? TARGET_C : (cnt_q[i] + ONE_C);
            end else begin
               // First matching OS of a new run (or first after a substate
               // change): restart the run on this signature.
               cnt_d[i]     = ONE_C;
               sig_d[i]     = lane_os[47:8];
               sig_vld_d[i] = 1'b1;
            end
         end else if (substate_chg) begin
            // A substate change breaks every run, including idle lanes.
            cnt_d[i]     = '0;
            sig_vld_d[i] = 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Aggregate flags from the next-state counts, so they move on the same
   // edge as lane_count.
   //---------------------------------------------------------------------------
   always_comb begin
      any_done_d = 1'b0;
      all_done_d = |lane_enable;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_enable[i]) begin
            if (cnt_d[i] == TARGET_C) begin
               any_done_d = 1'b1;
            end else begin
               all_done_d = 1'b0;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Capture of rate ID / upconfigure on the rising edge of all_done, taken
   // from the next-state signature of the lowest-index enabled lane (that
   // lane is guaranteed to hold a valid signature since its count is TARGET).
   //---------------------------------------------------------------------------
   always_comb begin
      rate_id_d  = rate_id_q;
      upconfig_d = upconfig_q;
      cap_found  = 1'b0;
      if (clear) begin
         rate_id_d  = 8'h00;
         upconfig_d = 1'b0;
      end else if (all_done_d && !all_done_q) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_enable[i] && !cap_found) begin
               cap_found  = 1'b1;
               rate_id_d  = sig_d[i][31:24];
               upconfig_d = sig_d[i][38];
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            cnt_q[i] <= '0;
            sig_q[i] <= '0;
         end
         sig_vld_q       <= '0;
         match_q         <= '0;
         prev_substate_q <= 4'd0;
         all_done_q      <= 1'b0;
         any_done_q      <= 1'b0;
         rate_id_q       <= 8'h00;
         upconfig_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            cnt_q[i] <= cnt_d[i];
            sig_q[i] <= sig_d[i];
         end
         sig_vld_q       <= sig_vld_d;
         match_q         <= match_d;
         prev_substate_q <= substate;
         all_done_q      <= all_done_d;
         any_done_q      <= any_done_d;
         rate_id_q       <= rate_id_d;
         upconfig_q      <= upconfig_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   always_comb begin
      lane_count = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_count[CNT_W*i +: CNT_W] = cnt_q[i];
      end
   end

   assign lane_match = match_q;
   assign all_done   = all_done_q;
   assign any_done   = any_done_q;
   assign rate_id    = rate_id_q;
   assign upconfig   = upconfig_q;

   // Symbols 0, 6 and 11..15 carry nothing this block looks at; they are
   // folded together here so they are visibly consumed.
   logic unused_os_bits;
   always_comb begin
      unused_os_bits = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         unused_os_bits = unused_os_bits ^ (^os_data[128*i +: 8])
                                         ^ (^os_data[128*i+48 +: 8])
                                         ^ (^os_data[128*i+88 +: 40]);
      end
   end

endmodule

// File: tb/tb_rx_os_lane_tracker.sv
//------------------------------------------------------------------------------
// tb_rx_os_lane_tracker
// Directed scenarios plus a randomized run, all checked against a behavioural
// model of the lane tracker kept in this file.
//------------------------------------------------------------------------------
module tb_rx_os_lane_tracker;

   localparam int L   = 4;
   localparam int CW  = 5;
   localparam int TGT = 8;

   localparam logic [7:0] PAD = 8'hF7;
   localparam logic [7:0] ID1 = 8'h2A;
   localparam logic [7:0] ID2 = 8'h25;

   //---------------------------------------------------------------------------
   // Clock / reset
   //---------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic               clear       = 1'b0;
   logic [3:0]         substate    = 4'd0;
   logic [7:0]         link_number = 8'd0;
   logic [L-1:0]       lane_enable = '0;
   logic [L-1:0]       os_valid    = '0;
   logic [L*128-1:0]   os_data     = '0;
   logic [L*CW-1:0]    lane_count;
   logic [L-1:0]       lane_match;
   logic               all_done;
   logic               any_done;
   logic [7:0]         rate_id;
   logic               upconfig;

   rx_os_lane_tracker #(
      .NUM_LANES (L),
      .CNT_W     (CW),
      .TARGET    (TGT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .substate    (substate),
      .link_number (link_number),
      .lane_enable (lane_enable),
      .os_valid    (os_valid),
      .os_data     (os_data),
      .lane_count  (lane_count),
      .lane_match  (lane_match),
      .all_done    (all_done),
      .any_done    (any_done),
      .rate_id     (rate_id),
      .upconfig    (upconfig)
   );

   int n_cmp = 0;
   int n_bad = 0;

   //---------------------------------------------------------------------------
   // Reference model
   //---------------------------------------------------------------------------
   int           m_cnt    [L];
   logic [39:0]  m_sig    [L];
   bit           m_sig_ok [L];
   logic [L-1:0] m_match;
   bit           m_all;
   bit           m_any;
   logic [7:0]   m_rate;
   bit           m_up;
   logic [3:0]   m_prev_ss;

   task automatic model_reset();
      for (int i = 0; i < L; i++) begin
         m_cnt[i]    = 0;
         m_sig[i]    = '0;
         m_sig_ok[i] = 0;
      end
      m_match   = '0;
      m_all     = 0;
      m_any     = 0;
      m_rate    = 8'h00;
      m_up      = 0;
      m_prev_ss = 4'd0;
   endtask

   function automatic bit rule_ok(input logic [3:0] ss, input logic [127:0] os, input int lane);
      bit         ts1;
      bit         ts2;
      logic [7:0] lk;
      logic [7:0] ln;
      lk  = os[15:8];
      ln  = os[23:16];
      ts1 = 1;
      ts2 = 1;
      for (int k = 7; k <= 10; k++) begin
         if (os[8*k +: 8] != ID1) ts1 = 0;
         if (os[8*k +: 8] != ID2) ts2 = 0;
      end
      case (ss)
         4'd2:      return (ts1 || ts2) && lk == PAD && ln == PAD;
         4'd3:      return ts2 && lk == PAD && ln == PAD;
         4'd4:      return ts1 && lk == link_number && ln == PAD;
         4'd5, 4'd6: return ts1 && lk == link_number && ln == 8'(lane);
         4'd8:      return ts2 && lk == link_number && ln == 8'(lane);
         default:   return 1'b0;
      endcase
   endfunction

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_update();
      bit           chg;
      bit           ok;
      bit           new_all;
      bit           new_any;
      int           n_en;
      int           n_done;
      logic [127:0] os;
      chg       = (substate != m_prev_ss);
      m_prev_ss = substate;
      for (int i = 0; i < L; i++) begin
         os = os_data[128*i +: 128];
         if (clear) begin
            m_cnt[i] = 0; m_sig_ok[i] = 0; m_match[i] = 0;
         end else if (os_valid[i]) begin
            ok         = rule_ok(substate, os, i);
            m_match[i] = ok;
            if (!ok) begin
               m_cnt[i] = 0; m_sig_ok[i] = 0;
            end else if (m_sig_ok[i] && !chg && m_sig[i] == os[47:8]) begin
               m_cnt[i] = (m_cnt[i] < TGT) ? m_cnt[i] + 1 : TGT;
            end else begin
               m_cnt[i] = 1; m_sig[i] = os[47:8]; m_sig_ok[i] = 1;
            end
         end else if (chg) begin
            m_cnt[i] = 0; m_sig_ok[i] = 0;
         end
      end
      n_en   = 0;
      n_done = 0;
      for (int i = 0; i < L; i++) begin
         if (lane_enable[i]) begin
            n_en++;
            if (m_cnt[i] == TGT) n_done++;
         end
      end
      new_all = (n_en > 0) && (n_done == n_en);
      new_any = (n_done > 0);
      if (clear) begin
         m_rate = 8'h00; m_up = 0;
      end else if (new_all && !m_all) begin
         for (int i = L - 1; i >= 0; i--) begin
            if (lane_enable[i]) begin
               m_rate = m_sig[i][31:24];
               m_up   = m_sig[i][38];
            end
         end
      end
      m_all = new_all;
      m_any = new_any;
   endtask

   //---------------------------------------------------------------------------
   // Driver tasks
   //---------------------------------------------------------------------------
   function automatic logic [127:0] make_os(input logic [7:0] id, input logic [7:0] lk,
                                            input logic [7:0] ln, input logic [7:0] rate,
                                            input logic [7:0] s5);
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      v[15:8]  = lk;
      v[23:16] = ln;
      v[31:24] = 8'h10;
      v[39:32] = rate;
      v[47:40] = s5;
      for (int k = 7; k <= 10; k++) v[8*k +: 8] = id;
      return v;
   endfunction

   task automatic set_os(input int lane, input logic [7:0] id, input logic [7:0] lk,
                         input logic [7:0] ln, input logic [7:0] rate, input logic [7:0] s5);
      os_data[128*lane +: 128] = make_os(id, lk, ln, rate, s5);
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      os_valid = '0;
      tick();
      clear    = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   // Scenarios
   //---------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (lane_count !== '0) begin n_bad++; $display("FAIL reset_count: got %h want 0", lane_count); end
      n_cmp++; if (lane_match !== '0) begin n_bad++; $display("FAIL reset_match: got %b want 0", lane_match); end
      n_cmp++; if (all_done !== 1'b0 || any_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got all=%b any=%b want 0/0", all_done, any_done); end
      n_cmp++; if (rate_id !== 8'h00 || upconfig !== 1'b0) begin n_bad++; $display("FAIL reset_capture: got rate=%h up=%b want 00/0", rate_id, upconfig); end
      reset = 1'b0;
      model_reset();
      #2;
   endtask

   task automatic test_polling_done();
      substate    = 4'd2;
      link_number = 8'd1;
      lane_enable = 4'b0011;
      os_valid    = 4'b0011;
      for (int k = 1; k <= 8; k++) begin
         set_os(0, ID2, PAD, PAD, 8'h1C, 8'h40);
         set_os(1, ID2, PAD, PAD, 8'h1C, 8'h40);
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (lane_count[CW*i +: CW] !== CW'(k)) begin
               n_bad++; $display("FAIL poll_count lane %0d step %0d: got %0d want %0d", i, k, lane_count[CW*i +: CW], k);
            end
         end
         n_cmp++;
         if (all_done !== 1'(k == 8)) begin
            n_bad++; $display("FAIL poll_all_done step %0d: got %b want %b", k, all_done, k == 8);
         end
      end
      n_cmp++; if (rate_id !== 8'h1C) begin n_bad++; $display("FAIL poll_rate_id: got %h want 1c", rate_id); end
      n_cmp++; if (upconfig !== 1'b1) begin n_bad++; $display("FAIL poll_upconfig: got %b want 1", upconfig); end
      n_cmp++; if (lane_match !== 4'b0011) begin n_bad++; $display("FAIL poll_match: got %b want 0011", lane_match); end
   endtask

   task automatic test_bad_os();
      int e0;
      int e1;
      do_clear();
      n_cmp++; if (lane_count !== '0 || rate_id !== 8'h00) begin n_bad++; $display("FAIL clear_state: got cnt=%h rate=%h want 0/00", lane_count, rate_id); end
      lane_enable = 4'b0011;
      os_valid    = 4'b0011;
      for (int k = 1; k <= 13; k++) begin
         set_os(0, ID2, (k == 5) ? 8'hAA : PAD, PAD, 8'h05, 8'h00);
         set_os(1, ID2, PAD, PAD, 8'h06, 8'h40);
         tick();
         e0 = (k <= 4) ? k : k - 5;
         e1 = (k < TGT) ? k : TGT;
         n_cmp++;
         if (lane_count[0 +: CW] !== CW'(e0)) begin n_bad++; $display("FAIL bad_os_lane0 step %0d: got %0d want %0d", k, lane_count[0 +: CW], e0); end
         n_cmp++;
         if (lane_count[CW +: CW] !== CW'(e1)) begin n_bad++; $display("FAIL bad_os_lane1 step %0d: got %0d want %0d", k, lane_count[CW +: CW], e1); end
         n_cmp++;
         if (any_done !== 1'(k >= 8) || all_done !== 1'(k >= 13)) begin
            n_bad++; $display("FAIL bad_os_done step %0d: got any=%b all=%b want %b/%b", k, any_done, all_done, k >= 8, k >= 13);
         end
         if (k == 5) begin
            n_cmp++;
            if (lane_match[0] !== 1'b0) begin n_bad++; $display("FAIL bad_os_match: got %b want 0", lane_match[0]); end
         end
      end
      // Lane 0 is the lowest enabled lane, so its signature is captured.
      n_cmp++; if (rate_id !== 8'h05 || upconfig !== 1'b0) begin n_bad++; $display("FAIL bad_os_capture: got rate=%h up=%b want 05/0", rate_id, upconfig); end
   endtask

   task automatic test_substate_link();
      int t_ss [14] = '{4, 4, 4, 4, 4, 4, 5, 5, 6, 6, 5, 5, 5, 4};
      int t_v  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
      int t_lk [14] = '{1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      int t_ln [14] = '{247, 247, 247, 247, 247, 247, 0, 0, 0, 0, 0, 0, 0, 0};
      int t_c  [14] = '{1, 2, 3, 0, 1, 2, 1, 2, 1, 2, 0, 1, 2, 0};
      int t_m  [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      do_clear();
      link_number = 8'd1;
      lane_enable = 4'b0001;
      for (int s = 0; s < 14; s++) begin
         substate = 4'(t_ss[s]);
         os_valid = {3'b000, 1'(t_v[s])};
         set_os(0, ID1, 8'(t_lk[s]), 8'(t_ln[s]), 8'h02, 8'h00);
         tick();
         n_cmp++;
         if (lane_count[0 +: CW] !== CW'(t_c[s]) || lane_match[0] !== 1'(t_m[s])) begin
            n_bad++; $display("FAIL substate_link step %0d: got cnt=%0d match=%b want %0d/%0d",
                              s, lane_count[0 +: CW], lane_match[0], t_c[s], t_m[s]);
         end
      end
   endtask

   task automatic test_signature();
      do_clear();
      substate    = 4'd2;
      lane_enable = 4'b0001;
      os_valid    = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         set_os(0, ID1, PAD, PAD, (k % 2 == 1) ? 8'h03 : 8'h02, 8'h00);
         tick();
         n_cmp++;
         if (lane_count[0 +: CW] !== CW'(1)) begin n_bad++; $display("FAIL sig_alternate step %0d: got %0d want 1", k, lane_count[0 +: CW]); end
      end
      for (int j = 0; j < 4; j++) begin
         set_os(0, ID1, PAD, PAD, 8'h03, 8'h00);
         tick();
         n_cmp++;
         if (lane_count[0 +: CW] !== CW'(j + 2)) begin n_bad++; $display("FAIL sig_constant step %0d: got %0d want %0d", j, lane_count[0 +: CW], j + 2); end
      end
   endtask

   task automatic test_saturate_clear();
      int e;
      do_clear();
      substate    = 4'd2;
      lane_enable = 4'b0001;
      os_valid    = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         set_os(0, ID1, PAD, PAD, 8'h07, 8'h40);
         tick();
         e = (k < TGT) ? k : TGT;
         n_cmp++;
         if (lane_count[0 +: CW] !== CW'(e) || all_done !== 1'(k >= TGT)) begin
            n_bad++; $display("FAIL saturate step %0d: got cnt=%0d all=%b want %0d/%b", k, lane_count[0 +: CW], all_done, e, k >= TGT);
         end
      end
      n_cmp++; if (rate_id !== 8'h07 || upconfig !== 1'b1) begin n_bad++; $display("FAIL saturate_capture: got rate=%h up=%b want 07/1", rate_id, upconfig); end
      clear = 1'b1;
      set_os(0, ID1, PAD, PAD, 8'h07, 8'h40);
      tick();
      clear = 1'b0;
      n_cmp++;
      if (lane_count !== '0 || lane_match !== '0 || all_done !== 1'b0 || rate_id !== 8'h00 || upconfig !== 1'b0) begin
         n_bad++; $display("FAIL clear_with_valid: got cnt=%h match=%b all=%b rate=%h up=%b want zeros", lane_count, lane_match, all_done, rate_id, upconfig);
      end
   endtask

   task automatic test_enable_zero();
      do_clear();
      substate    = 4'd3;
      lane_enable = 4'b0000;
      os_valid    = 4'b0011;
      for (int k = 1; k <= 10; k++) begin
         set_os(0, ID2, PAD, PAD, 8'h0A, 8'h00);
         set_os(1, ID2, PAD, PAD, 8'h0B, 8'h40);
         tick();
      end
      n_cmp++; if (lane_count[0 +: 2*CW] !== {CW'(TGT), CW'(TGT)}) begin n_bad++; $display("FAIL enable_zero_count: got %h want full", lane_count[0 +: 2*CW]); end
      n_cmp++; if (all_done !== 1'b0 || any_done !== 1'b0) begin n_bad++; $display("FAIL enable_zero_done: got all=%b any=%b want 0/0", all_done, any_done); end
      // Enabling only lane 1 raises all_done and captures lane 1's fields.
      lane_enable = 4'b0010;
      set_os(0, ID2, PAD, PAD, 8'h0A, 8'h00);
      set_os(1, ID2, PAD, PAD, 8'h0B, 8'h40);
      tick();
      n_cmp++;
      if (all_done !== 1'b1 || rate_id !== 8'h0B || upconfig !== 1'b1) begin
         n_bad++; $display("FAIL enable_lane1_capture: got all=%b rate=%h up=%b want 1/0b/1", all_done, rate_id, upconfig);
      end
   endtask

   task automatic test_reset_mid();
      do_clear();
      substate    = 4'd2;
      lane_enable = 4'b0001;
      os_valid    = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
         set_os(0, ID2, PAD, PAD, 8'h33, 8'h40);
         tick();
      end
      n_cmp++; if (all_done !== 1'b1 || rate_id !== 8'h33) begin n_bad++; $display("FAIL pre_reset: got all=%b rate=%h want 1/33", all_done, rate_id); end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (lane_count !== '0 || lane_match !== '0 || all_done !== 1'b0 || any_done !== 1'b0 || rate_id !== 8'h00 || upconfig !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: got cnt=%h match=%b all=%b any=%b rate=%h up=%b want zeros",
                           lane_count, lane_match, all_done, any_done, rate_id, upconfig);
      end
      #1;
      reset = 1'b0;
      model_reset();
      set_os(0, ID2, PAD, PAD, 8'h33, 8'h40);
      tick();
      n_cmp++; if (lane_count[0 +: CW] !== CW'(1)) begin n_bad++; $display("FAIL post_reset_count: got %0d want 1", lane_count[0 +: CW]); end
   endtask

   task automatic test_random();
      logic [7:0] p_id [L];
      logic [7:0] p_lk [L];
      logic [7:0] p_ln [L];
      logic [7:0] p_rt [L];
      logic [7:0] p_s5 [L];
      do_clear();
      link_number = 8'd1;
      lane_enable = 4'b1111;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(15) == 0) begin
            case ($urandom_range(6))
               0: substate = 4'd2;
               1: substate = 4'd3;
               2: substate = 4'd4;
               3: substate = 4'd5;
               4: substate = 4'd6;
               5: substate = 4'd8;
               default: substate = 4'd7;
            endcase
         end
         if ($urandom_range(31) == 0) lane_enable = 4'($urandom);
         clear = ($urandom_range(31) == 0);
         for (int i = 0; i < L; i++) begin
            if (c == 0 || $urandom_range(7) == 0) begin
               case ($urandom_range(4))
                  0, 1:    p_id[i] = ID1;
                  2, 3:    p_id[i] = ID2;
                  default: p_id[i] = 8'($urandom);
               endcase
               case ($urandom_range(2))
                  0:       p_lk[i] = PAD;
                  1:       p_lk[i] = link_number;
                  default: p_lk[i] = 8'($urandom_range(255));
               endcase
               case ($urandom_range(2))
                  0:       p_ln[i] = PAD;
                  1:       p_ln[i] = 8'(i);
                  default: p_ln[i] = 8'($urandom_range(3));
               endcase
               p_rt[i] = $urandom_range(1) ? 8'h02 : 8'h03;
               p_s5[i] = $urandom_range(1) ? 8'h40 : 8'h00;
            end
            os_valid[i] = ($urandom_range(3) != 0);
            set_os(i, p_id[i], p_lk[i], p_ln[i], p_rt[i], p_s5[i]);
         end
         tick();
         for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (lane_count[CW*i +: CW] !== CW'(m_cnt[i])) begin
               n_bad++; $display("FAIL rnd_count lane %0d cycle %0d: got %0d want %0d", i, c, lane_count[CW*i +: CW], m_cnt[i]);
            end
         end
         n_cmp++; if (lane_match !== m_match) begin n_bad++; $display("FAIL rnd_match cycle %0d: got %b want %b", c, lane_match, m_match); end
         n_cmp++; if (all_done !== m_all || any_done !== m_any) begin n_bad++; $display("FAIL rnd_done cycle %0d: got all=%b any=%b want %b/%b", c, all_done, any_done, m_all, m_any); end
         n_cmp++; if (rate_id !== m_rate || upconfig !== m_up) begin n_bad++; $display("FAIL rnd_capture cycle %0d: got rate=%h up=%b want %h/%b", c, rate_id, upconfig, m_rate, m_up); end
      end
      clear = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   // Sequence and report
   //---------------------------------------------------------------------------
   initial begin
      model_reset();
      test_reset();
      test_polling_done();
      test_bad_os();
      test_substate_link();
      test_signature();
      test_saturate_clear();
      test_enable_zero();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
